// File: rtl/mult_sequencer_pkg.sv
// mult_seq_pkg
// Shared types and constants for the multiply sequencer slice.
// Provides the FSM state encoding, datapath widths, the default watchdog
// limit and a helper that derives the N/Z flags from a result word.
package mult_seq_pkg;

  localparam int WORD_W                 = 32;
  localparam int REG_W                  = 4;
  localparam int TIMEOUT_CYCLES_DEFAULT = 127;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [REG_W-1:0]  reg_idx_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_WAIT   = 3'd3,
    ST_ACCUM  = 3'd4,
    ST_WB     = 3'd5
  } state_t;

  // Returns {N, Z} for a result word; C and V are never produced by a multiply.
  function automatic logic [1:0] calc_nz(input word_t value);
    return {value[WORD_W-1], (value == '0)};
  endfunction

endpackage

// File: rtl/mult_sequencer_if.sv
// mult_sequencer_if
// Bundles the three handshake groups around the sequencer:
//   command  : cmd_valid/cmd_ready plus operands and control bits from decode
//   multiply : mult_enable, mult_a/mult_b out; mult_result, mult_ready back
//   writeback: wb_valid/wb_ready, wb_data, wb_rd, flag write enable and N/Z
//   status   : busy, timeout_err
// The slave modport is the sequencer's view; master is the surrounding
// pipeline (decode, multiplier and writeback) as seen from outside.
interface mult_sequencer_if;
  import mult_seq_pkg::*;

  logic     cmd_valid;
  logic     cmd_ready;
  logic     cmd_accumulate;
  logic     cmd_set_flags;
  word_t    cmd_rm;
  word_t    cmd_rs;
  word_t    cmd_rn;
  reg_idx_t cmd_rd;

  logic     mult_enable;
  word_t    mult_a;
  word_t    mult_b;
  word_t    mult_result;
  logic     mult_ready;

  logic     wb_valid;
  logic     wb_ready;
  word_t    wb_data;
  reg_idx_t wb_rd;
  logic     wb_flags_we;
  logic     wb_n;
  logic     wb_z;

  logic     busy;
  logic     timeout_err;

  modport slave (
    input  cmd_valid, cmd_accumulate, cmd_set_flags, cmd_rm, cmd_rs, cmd_rn, cmd_rd,
    input  mult_result, mult_ready, wb_ready,
    output cmd_ready, mult_enable, mult_a, mult_b,
    output wb_valid, wb_data, wb_rd, wb_flags_we, wb_n, wb_z, busy, timeout_err
  );

  modport master (
    output cmd_valid, cmd_accumulate, cmd_set_flags, cmd_rm, cmd_rs, cmd_rn, cmd_rd,
    output mult_result, mult_ready, wb_ready,
    input  cmd_ready, mult_enable, mult_a, mult_b,
    input  wb_valid, wb_data, wb_rd, wb_flags_we, wb_n, wb_z, busy, timeout_err
  );

endinterface

// File: rtl/mult_sequencer_watchdog.sv
// mult_seq_watchdog
// Cycle counter guarding the wait for multiplier completion.
// Ports:
//   sysclk, reset : clock and synchronous active-high reset
//   clear         : zero the count (asserted while the multiply settles)
//   enable        : count one cycle
//   expired       : count has reached LIMIT
module mult_seq_watchdog #(
  parameter int CNT_W = 8,
  parameter int LIMIT = 127
) (
  input  logic sysclk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [CNT_W-1:0] count;

  // Saturates at LIMIT so a stray enable after expiry cannot wrap the count.
  always_ff @(posedge sysclk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == CNT_W'(LIMIT));

endmodule

// File: rtl/mult_sequencer.sv
// mult_sequencer
// Issue-side controller for the iterative Booth multiplier. Accepts a MUL/MLA
// command, starts the multiplier, waits for its completion under a watchdog,
// adds the accumulate operand for MLA, derives N/Z and offers the result to
// writeback over a valid/ready handshake.
// Ports:
//   sysclk, reset : clock and synchronous active-high reset
//   bus           : mult_sequencer_if.slave (command, multiplier, writeback,
//                   busy and timeout_err)
module mult_sequencer
  import mult_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
  parameter int CNT_W          = 8
) (
  input logic              sysclk,
  input logic              reset,
  mult_sequencer_if.slave  bus
);

  state_t   state, state_next;
  word_t    rm_q, rs_q, rn_q, prod_q, wb_data_q;
  reg_idx_t rd_q;
  logic     acc_q, sf_q, n_q, z_q;
  word_t    acc_sum;

  logic     cmd_ready, mult_enable, wb_valid, wb_flags_we, timeout_err;
  logic     wd_clear, wd_enable, wd_expired;

  mult_seq_watchdog #(
    .CNT_W (CNT_W),
    .LIMIT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .sysclk  (sysclk),
    .reset   (reset),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .expired (wd_expired)
  );

  // Carry out of the add is discarded; the result is modulo 2^32.
  assign acc_sum = prod_q + (acc_q ? rn_q : '0);

  // State register plus the operand/result registers. The product is only
  // captured on a genuine completion, never on the abort cycle.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state     <= ST_IDLE;
      rm_q      <= '0;
      rs_q      <= '0;
      rn_q      <= '0;
      rd_q      <= '0;
      acc_q     <= 1'b0;
      sf_q      <= 1'b0;
      prod_q    <= '0;
      wb_data_q <= '0;
      n_q       <= 1'b0;
      z_q       <= 1'b0;
    end else begin
      state <= state_next;
      if (state == ST_IDLE && bus.cmd_valid) begin
        rm_q  <= bus.cmd_rm;
        rs_q  <= bus.cmd_rs;
        rn_q  <= bus.cmd_rn;
        rd_q  <= bus.cmd_rd;
        acc_q <= bus.cmd_accumulate;
        sf_q  <= bus.cmd_set_flags;
      end
      if (state == ST_WAIT && bus.mult_ready && !wd_expired) begin
        prod_q <= bus.mult_result;
      end
      if (state == ST_ACCUM) begin
        wb_data_q  <= acc_sum;
        {n_q, z_q} <= calc_nz(acc_sum);
      end
    end
  end

  // Next-state and handshake outputs. ISSUE holds off the start pulse until
  // the multiplier reports idle, which absorbs a job left running across a
  // reset. SETTLE ignores mult_ready because the multiplier only drops it a
  // cycle after the start pulse.
  always_comb begin
    state_next  = state;
    cmd_ready   = 1'b0;
    mult_enable = 1'b0;
    wd_clear    = 1'b0;
    wd_enable   = 1'b0;
    timeout_err = 1'b0;
    wb_valid    = 1'b0;
    wb_flags_we = 1'b0;
    unique case (state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (bus.cmd_valid) state_next = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (bus.mult_ready) begin
          mult_enable = 1'b1;
          state_next  = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        wd_clear   = 1'b1;
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        wd_enable = 1'b1;
        if (wd_expired) begin
          timeout_err = 1'b1;
          state_next  = ST_IDLE;
        end else if (bus.mult_ready) begin
          state_next = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        state_next = ST_WB;
      end
      ST_WB: begin
        wb_valid    = 1'b1;
        wb_flags_we = sf_q;
        if (bus.wb_ready) state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign bus.cmd_ready   = cmd_ready;
  assign bus.mult_enable = mult_enable;
  assign bus.mult_a      = rm_q;
  assign bus.mult_b      = rs_q;
  assign bus.wb_valid    = wb_valid;
  assign bus.wb_data     = wb_data_q;
  assign bus.wb_rd       = rd_q;
  assign bus.wb_flags_we = wb_flags_we;
  assign bus.wb_n        = n_q;
  assign bus.wb_z        = z_q;
  assign bus.busy        = (state != ST_IDLE);
  assign bus.timeout_err = timeout_err;

endmodule

// File: doc/mult_sequencer.md
# mult_sequencer

Issue-side controller for the iterative Booth multiplier in the ARM7 execute stage. Accepts MUL/MLA commands from decode, drives the multiplier's enable/operand interface, waits for completion, optionally adds the accumulate operand, computes N/Z, and presents the result to register writeback over a valid/ready handshake. A watchdog aborts a multiply whose completion never arrives.

## Interface
- TIMEOUT_CYCLES, 127: max cycles from SETTLE entry to observed `mult_ready`=1 before abort (2..255)
- CNT_W, 8: watchdog counter width; must hold TIMEOUT_CYCLES
- sysclk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high; sampled on rising edge of sysclk
- cmd_valid  in  1  decode presents a multiply command
- cmd_ready  out  1  sequencer can accept (IDLE only)
- cmd_accumulate  in  1  1=MLA (add cmd_rn), 0=MUL
- cmd_set_flags  in  1  S bit; update N/Z
- cmd_rm, cmd_rs, cmd_rn  in  32 each  multiplicand, multiplier, accumulate operand
- cmd_rd  in  4  destination register
- mult_enable  out  1  start pulse to multiplier
- mult_a, mult_b  out  32 each  operands (Rm, Rs), held stable ISSUE through WAIT
- mult_result  in  32  low 32 bits of product
- mult_ready  in  1  1 = multiplier idle/result valid
- wb_valid  out  1  result available
- wb_ready  in  1  writeback accepts
- wb_data  out  32  result
- wb_rd  out  4  destination
- wb_flags_we, wb_n, wb_z  out  1 each  flag write enable, N, Z
- busy  out  1  state != IDLE
- timeout_err  out  1  one-cycle abort pulse

## Operation
- States: IDLE, ISSUE, SETTLE, WAIT, ACCUM, WB.
- IDLE: cmd_ready=1. On cmd_valid: register rm/rs/rn/rd/accumulate/set_flags -> ISSUE.
- ISSUE: if mult_ready=1, mult_enable=1 this cycle -> SETTLE; else stay, mult_enable=0 (multiplier still finishing a pre-reset job).
- SETTLE: one cycle, mult_ready ignored (multiplier drops ready after start); watchdog cleared -> WAIT.
- WAIT: watchdog increments each cycle; mult_ready=1 -> capture mult_result, -> ACCUM. Count reaches TIMEOUT_CYCLES first -> timeout_err=1 for one cycle, -> IDLE, no writeback.
- ACCUM: result = product + (accumulate ? rn : 0), modulo 2^32, carry discarded. N=result[31], Z=(result==0). C/V never produced. -> WB.
- WB: wb_valid=1, outputs held stable until wb_ready=1 -> IDLE. wb_flags_we=set_flags.
- Signed and unsigned operands give identical low 32 bits; no sign handling here.

## Timing
- Reset (any state, including mid-WAIT): state IDLE; cmd_ready=1 in the first cycle after reset; mult_enable, wb_valid, wb_flags_we, wb_n, wb_z, timeout_err, busy=0; wb_data, mult_a, mult_b, wb_rd=0. An in-flight multiplier job is not cancelled; ISSUE's mult_ready gate absorbs it.
- Accept at edge T -> mult_enable high in cycle T+1 (if mult_ready=1). mult_ready first sampled in cycle T+3.
- mult_ready sampled 1 at edge E -> wb_valid high from edge E+2 (ACCUM then WB).
- Back-to-back: cmd_ready returns the cycle after the WB handshake edge; no command overlap.
- cmd_valid in any non-IDLE state is ignored (cmd_ready=0).
- Timeout: with mult_ready stuck 0, timeout_err pulses exactly TIMEOUT_CYCLES cycles after WAIT entry; cmd_ready=1 the following cycle.
- wb_ready high while wb_valid low: no effect.

## Structure
- Package mult_seq_pkg: state enum (3-bit encoding), WORD_W=32, REG_W=4, default TIMEOUT_CYCLES.
- One sub-module: mult_seq_watchdog (clear, enable, count, expired) instantiated in the top.
- Top holds FSM, operand/result registers, accumulate adder and N/Z logic.

## Test plan
- MUL 7 x 6, S=1, multiplier model returns after 34 cycles -> wb_data=0x0000002A, N=0, Z=0, wb_flags_we=1, wb_rd echoed.
- MLA 0xFFFFFFFF x 1 + 1, S=1 -> wb_data=0x00000000, Z=1, N=0.
- MUL 0xFFFFFFFD x 5, S=0 -> wb_data=0xFFFFFFF1, wb_flags_we=0; second command issued same cycle cmd_ready rises -> accepted.
- wb_ready held low 5 cycles in WB -> wb_valid, wb_data, flags stable all 5 cycles; cmd_ready stays 0.
- mult_ready stuck 0 after SETTLE -> timeout_err single pulse TIMEOUT_CYCLES cycles after WAIT entry, no wb_valid, back to IDLE.
- reset asserted mid-WAIT with mult_ready=0 -> all outputs at reset values next cycle; new command waits in ISSUE with mult_enable=0 until mult_ready=1, then completes correctly.
